// File: rtl/fp8_pkg.sv
// Shared FP8 definitions for the MAC datapath: field widths, bias, saturation
// constants, the field-level FP8 struct and the accumulator state encoding.
package fp8_pkg;

  localparam int FP8_EXP_W  = 4;
  localparam int FP8_FRAC_W = 3;
  localparam int FP8_W      = 1 + FP8_EXP_W + FP8_FRAC_W;
  localparam int FP8_BIAS   = 7;

  localparam logic [FP8_W-1:0] FP8_ZERO    = 8'h00;
  localparam logic [FP8_W-1:0] FP8_POS_MAX = 8'h7F;
  localparam logic [FP8_W-1:0] FP8_NEG_MAX = 8'hFF;

  typedef struct packed {
    logic                  sign;
    logic [FP8_EXP_W-1:0]  expo;
    logic [FP8_FRAC_W-1:0] frac;
  } fp8_t;

  typedef enum logic {
    ACC_EMPTY = 1'b0,
    ACC_ACCUM = 1'b1
  } acc_state_e;

  function automatic logic fp8_is_zero(input fp8_t v);
    return v.expo == '0;
  endfunction

endpackage

// File: rtl/fp8_accum_if.sv
// Stream bundle around the FP8 accumulator: addend input with group marker,
// rounded group sum output, both with valid/ready handshakes.
interface fp8_accum_if;
  import fp8_pkg::*;

  logic [FP8_W-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [FP8_W-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/fp8_lzc.sv
// Combinational leading-zero counter; an all-zero input reports W.
module fp8_lzc #(
  parameter int W  = 12,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  din,
  output logic [CW-1:0] cnt
);

  // Ascending scan: the highest set bit is the last one to write cnt.
  always_comb begin
    cnt = CW'(W);
    for (int i = 0; i < W; i++) begin
      if (din[i]) cnt = CW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/fp8_accum.sv
// Streaming FP8 group accumulator with an extended-precision running sum and a
// one-entry output buffer. Define FP8_ACCUM_RNE_EN for round-to-nearest-even output.
module fp8_accum
  import fp8_pkg::*;
#(
  parameter int EXP_BIAS = FP8_BIAS,
  parameter int ACC_FRAC = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  fp8_accum_if.slave   bus
);

  localparam int MW       = 1 + FP8_FRAC_W + ACC_FRAC;
  localparam int LZW      = $clog2(MW + 1);
  localparam int EMAX_UNB = 15 - EXP_BIAS;
  localparam int EMIN_UNB = 1 - EXP_BIAS;
  localparam logic [MW-1:0] SAT_MANT = {1'b1, {FP8_FRAC_W{1'b1}}, {ACC_FRAC{1'b0}}};

  acc_state_e             state_q, state_d;
  logic                   acc_sign_q, acc_sign_d;
  logic [FP8_EXP_W-1:0]   acc_exp_q, acc_exp_d;
  logic [MW-1:0]          acc_mant_q, acc_mant_d;
  logic                   out_valid_q, out_valid_d;
  logic [FP8_W-1:0]       out_data_q, out_data_d;

  logic                   in_xfer, out_xfer;
  fp8_t                   op;
  logic                   op_zero;
  logic [FP8_EXP_W-1:0]   op_exp, a_exp, big_exp, sml_exp, diff;
  logic [MW-1:0]          op_mant, a_mant, big_mant, sml_mant, sml_sh;
  logic                   a_sign, big_sign, sml_sign, acc_bigger;
  logic [MW:0]            sum;
  logic [LZW-1:0]         lz;
  logic                   res_sign;
  logic [FP8_EXP_W-1:0]   res_exp;
  logic [MW-1:0]          res_mant;
  int                     res_e_unb;
  logic                   round_up;

  function automatic logic [FP8_W-1:0] to_fp8(input logic s, input logic [FP8_EXP_W-1:0] e,
                                              input logic [FP8_FRAC_W-1:0] f, input logic rnd);
    logic [FP8_FRAC_W:0] f_r;
    if (e == '0) return FP8_ZERO;
    f_r = {1'b0, f} + {{FP8_FRAC_W{1'b0}}, rnd};
    if (f_r[FP8_FRAC_W]) begin
      if (e == '1) return s ? FP8_NEG_MAX : FP8_POS_MAX;
      return {s, e + 4'd1, {FP8_FRAC_W{1'b0}}};
    end
    return {s, e, f_r[FP8_FRAC_W-1:0]};
  endfunction

  assign bus.in_ready  = !(out_valid_q && !bus.out_ready);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign in_xfer       = bus.in_valid && bus.in_ready;
  assign out_xfer      = out_valid_q && bus.out_ready;

  // Operand unpack; exponent 0 flushes to zero, and an EMPTY accumulator reads as zero.
  assign op      = fp8_t'(bus.in_data);
  assign op_zero = fp8_is_zero(op);
  assign op_exp  = op_zero ? '0 : op.expo;
  assign op_mant = op_zero ? '0 : {1'b1, op.frac, {ACC_FRAC{1'b0}}};
  assign a_sign  = (state_q == ACC_ACCUM) ? acc_sign_q : 1'b0;
  assign a_exp   = (state_q == ACC_ACCUM) ? acc_exp_q  : '0;
  assign a_mant  = (state_q == ACC_ACCUM) ? acc_mant_q : '0;

  // Align the smaller magnitude under the larger, then add or subtract.
  assign acc_bigger = {a_exp, a_mant} >= {op_exp, op_mant};
  assign big_sign   = acc_bigger ? a_sign  : op.sign;
  assign big_exp    = acc_bigger ? a_exp   : op_exp;
  assign big_mant   = acc_bigger ? a_mant  : op_mant;
  assign sml_sign   = acc_bigger ? op.sign : a_sign;
  assign sml_exp    = acc_bigger ? op_exp  : a_exp;
  assign sml_mant   = acc_bigger ? op_mant : a_mant;
  assign diff       = big_exp - sml_exp;
  assign sml_sh     = (int'(diff) >= MW) ? '0 : (sml_mant >> diff);
  assign sum        = (big_sign == sml_sign) ? ({1'b0, big_mant} + {1'b0, sml_sh})
                                             : ({1'b0, big_mant} - {1'b0, sml_sh});

  fp8_lzc #(.W(MW), .CW(LZW)) u_lzc (
    .din (sum[MW-1:0]),
    .cnt (lz)
  );

  // Normalize in the unbiased exponent domain, then clamp or flush.
  always_comb begin
    res_sign  = 1'b0;
    res_exp   = '0;
    res_mant  = '0;
    res_e_unb = int'(big_exp) - EXP_BIAS;
    if (sum != '0) begin
      if (sum[MW]) begin
        res_e_unb = res_e_unb + 1;
        res_mant  = sum[MW:1];
      end else begin
        res_e_unb = res_e_unb - int'(lz);
        res_mant  = sum[MW-1:0] << lz;
      end
      if (res_e_unb > EMAX_UNB) begin
        res_sign = big_sign;
        res_exp  = '1;
        res_mant = SAT_MANT;
      end else if (res_e_unb < EMIN_UNB) begin
        res_mant = '0;
      end else begin
        res_sign = big_sign;
        res_exp  = FP8_EXP_W'(res_e_unb + EXP_BIAS);
      end
    end
  end

`ifdef FP8_ACCUM_RNE_EN
  assign round_up = res_mant[ACC_FRAC-1] & ((|res_mant[ACC_FRAC-2:0]) | res_mant[ACC_FRAC]);
`else
  assign round_up = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    acc_sign_d  = acc_sign_q;
    acc_exp_d   = acc_exp_q;
    acc_mant_d  = acc_mant_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (out_xfer) out_valid_d = 1'b0;
    if (in_xfer) begin
      if (bus.in_last) begin
        state_d     = ACC_EMPTY;
        acc_sign_d  = 1'b0;
        acc_exp_d   = '0;
        acc_mant_d  = '0;
        out_valid_d = 1'b1;
        out_data_d  = to_fp8(res_sign, res_exp, res_mant[MW-2 -: FP8_FRAC_W], round_up);
      end else begin
        state_d    = ACC_ACCUM;
        acc_sign_d = res_sign;
        acc_exp_d  = res_exp;
        acc_mant_d = res_mant;
      end
    end
  end

  // State boundary: accumulator and output buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC_EMPTY;
      acc_sign_q  <= 1'b0;
      acc_exp_q   <= '0;
      acc_mant_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= FP8_ZERO;
    end else begin
      state_q     <= state_d;
      acc_sign_q  <= acc_sign_d;
      acc_exp_q   <= acc_exp_d;
      acc_mant_q  <= acc_mant_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

endmodule

// File: tb/tb_fp8_accum.sv
// Directed and randomized bench for fp8_accum against a value-level FP8 accumulation model.
module tb_fp8_accum;
  import fp8_pkg::*;

  localparam int ACC_FRAC = 8;
  localparam int MW       = 4 + ACC_FRAC;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fp8_accum_if bus ();

  fp8_accum #(.EXP_BIAS(FP8_BIAS), .ACC_FRAC(ACC_FRAC)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Value model: sign, exponent field (0 = zero) and mantissa scaled to MW bits.
  typedef struct {
    bit     s;
    int     e;
    longint m;
  } mval_t;

  function automatic mval_t m_zero();
    mval_t r;
    r.s = 0; r.e = 0; r.m = 0;
    return r;
  endfunction

  function automatic mval_t m_unpack(input logic [7:0] b);
    mval_t v;
    v.s = b[7];
    v.e = int'(b[6:3]);
    v.m = (v.e == 0) ? 0 : (longint'(8 + int'(b[2:0])) << ACC_FRAC);
    return v;
  endfunction

  function automatic mval_t m_add(input mval_t a_in, input mval_t b_in);
    mval_t a, b, r;
    int d, e;
    longint bm, mag;
    a = a_in; b = b_in;
    if (b.e > a.e || (b.e == a.e && b.m > a.m)) begin a = b_in; b = a_in; end
    d   = a.e - b.e;
    bm  = (d >= MW) ? 0 : (b.m >>> d);
    mag = (a.s == b.s) ? a.m + bm : a.m - bm;
    e   = a.e;
    r   = m_zero();
    if (mag == 0) return r;
    while (mag >= (longint'(1) << MW)) begin mag = mag >>> 1; e++; end
    while (mag < (longint'(1) << (MW - 1))) begin mag = mag << 1; e--; end
    if (e > 15) begin r.s = a.s; r.e = 15; r.m = longint'(15) << ACC_FRAC; return r; end
    if (e < 1) return r;
    r.s = a.s; r.e = e; r.m = mag;
    return r;
  endfunction

  function automatic logic [7:0] m_round(input mval_t v);
    longint frac;
    int e;
`ifdef FP8_ACCUM_RNE_EN
    longint rem, half;
`endif
    if (v.e == 0) return 8'h00;
    frac = (v.m >>> ACC_FRAC) - 8;
    e    = v.e;
`ifdef FP8_ACCUM_RNE_EN
    rem  = v.m % (longint'(1) << ACC_FRAC);
    half = longint'(1) << (ACC_FRAC - 1);
    if (rem > half || (rem == half && (frac % 2) == 1)) frac++;
`endif
    if (frac == 8) begin frac = 0; e++; end
    if (e > 15) return v.s ? 8'hFF : 8'h7F;
    return {v.s, 4'(e), 3'(frac)};
  endfunction

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp_v);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic l);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
  endtask

  // Present one addend (ready expected), then move to the next falling edge.
  task automatic push(input logic [7:0] d, input logic l);
    drive(1'b1, d, l);
    #1;
    chk1("push_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
  endtask

  task automatic idle();
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
  endtask

  function automatic logic [7:0] rand_operand();
    if ($urandom_range(0, 1) == 0)
      return {1'($urandom_range(0, 1)), 4'($urandom_range(5, 9)), 3'($urandom_range(0, 7))};
    return 8'($urandom_range(0, 255));
  endfunction

  mval_t      acc;
  logic [7:0] expq[$];
  logic [7:0] rd;
  logic       rl, have, rdy_exp;

  initial begin
    drive(1'b0, 8'h00, 1'b0);
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk8("rst_out_data", bus.out_data, 8'h00);
    chk1("rst_in_ready", bus.in_ready, 1'b1);
    rst_n = 1'b1;
    @(negedge clk);

    // 1.0 + 2.0
    push(8'h38, 1'b0);
    chk1("t1_no_early_valid", bus.out_valid, 1'b0);
    push(8'h40, 1'b1);
    chk1("t1_valid", bus.out_valid, 1'b1);
    chk8("t1_sum", bus.out_data, 8'h44);
    idle();
    chk1("t1_one_cycle", bus.out_valid, 1'b0);

    // 1.0 + 1.5, then an exactly cancelling group back-to-back
    push(8'h38, 1'b0);
    push(8'h3C, 1'b1);
    chk1("t2_valid", bus.out_valid, 1'b1);
    chk8("t2_sum", bus.out_data, 8'h42);
    push(8'h3C, 1'b0);
    chk1("t2_drained", bus.out_valid, 1'b0);
    push(8'hBC, 1'b1);
    chk1("t2_cancel_valid", bus.out_valid, 1'b1);
    chk8("t2_cancel_sum", bus.out_data, 8'h00);

    // Saturation both signs
    push(8'h7F, 1'b0);
    push(8'h7F, 1'b0);
    push(8'h7F, 1'b1);
    chk8("t3_pos_sat", bus.out_data, 8'h7F);
    push(8'hFF, 1'b0);
    push(8'hFF, 1'b1);
    chk8("t3_neg_sat", bus.out_data, 8'hFF);

    // Output rounding: above-half and exact tie
    push(8'h38, 1'b0);
    push(8'h1C, 1'b1);
`ifdef FP8_ACCUM_RNE_EN
    chk8("t4_round_above_half", bus.out_data, 8'h39);
`else
    chk8("t4_round_above_half", bus.out_data, 8'h38);
`endif
    push(8'h38, 1'b0);
    push(8'h18, 1'b1);
    chk8("t4_round_tie", bus.out_data, 8'h38);
    idle();

    // Backpressure: full buffer stalls input until the consumer drains
    bus.out_ready = 1'b0;
    push(8'h38, 1'b0);
    push(8'h40, 1'b1);
    chk8("t5_sum", bus.out_data, 8'h44);
    drive(1'b1, 8'h38, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("t5_stall_in_ready", bus.in_ready, 1'b0);
      @(negedge clk);
      chk1("t5_hold_valid", bus.out_valid, 1'b1);
      chk8("t5_hold_data", bus.out_data, 8'h44);
    end
    bus.out_ready = 1'b1;
    #1;
    chk1("t5_drain_in_ready", bus.in_ready, 1'b1);
    @(negedge clk);
    chk1("t5_next_valid", bus.out_valid, 1'b1);
    chk8("t5_next_data", bus.out_data, 8'h38);
    idle();
    chk1("t5_empty", bus.out_valid, 1'b0);

    // Asynchronous reset clears a pending output, then a partial sum
    bus.out_ready = 1'b0;
    push(8'h38, 1'b1);
    chk1("t6_pending", bus.out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk1("t6_async_valid", bus.out_valid, 1'b0);
    chk8("t6_async_data", bus.out_data, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    push(8'h40, 1'b0);
    push(8'h40, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk1("t6_mid_group_valid", bus.out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    push(8'h38, 1'b1);
    chk1("t6_after_valid", bus.out_valid, 1'b1);
    chk8("t6_discarded_partial", bus.out_data, 8'h38);
    idle();

    // Randomized groups with random backpressure against the value model
    acc  = m_zero();
    have = 1'b0;
    rd   = 8'h00;
    rl   = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      bus.out_ready = ($urandom_range(0, 3) != 0);
      if (!have) begin
        rd   = rand_operand();
        rl   = ($urandom_range(0, 3) == 0);
        have = 1'b1;
      end
      drive(($urandom_range(0, 5) != 0), rd, rl);
      #1;
      rdy_exp = !(expq.size() != 0 && !bus.out_ready);
      chk1("rnd_out_valid", bus.out_valid, expq.size() != 0);
      chk1("rnd_in_ready", bus.in_ready, rdy_exp);
      if (expq.size() != 0 && bus.out_ready) begin
        chk8("rnd_out_data", bus.out_data, expq[0]);
        void'(expq.pop_front());
      end
      if (bus.in_valid && rdy_exp) begin
        acc = m_add(acc, m_unpack(rd));
        if (rl) begin
          expq.push_back(m_round(acc));
          acc = m_zero();
        end
        have = 1'b0;
      end
      @(negedge clk);
    end
    drive(1'b0, 8'h00, 1'b0);
    bus.out_ready = 1'b1;
    #1;
    if (expq.size() != 0) begin
      chk8("rnd_final_data", bus.out_data, expq[0]);
      void'(expq.pop_front());
    end
    @(negedge clk);
    chk1("rnd_drained", bus.out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
